// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: holds decoded operands and control for the EX stage, with stall and flush.
// Optional stall/bubble performance counters are built when IDEX_PERF_CNT_EN is defined.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               In_Valid,
    input  logic [DATA_W-1:0]  In_PC,
    input  logic [DATA_W-1:0]  In_RnData,
    input  logic [DATA_W-1:0]  In_RmData,
    input  logic [DATA_W-1:0]  In_Imm,
    input  logic [REG_W-1:0]   In_Rn,
    input  logic [REG_W-1:0]   In_Rm,
    input  logic [REG_W-1:0]   In_Rd,
    input  logic               In_ALUSrc,
    input  logic [ALUOP_W-1:0] In_ALUOp,
    input  logic               In_MemRead,
    input  logic               In_MemWrite,
    input  logic               In_RegWrite,
    input  logic               In_MemToReg,
    input  logic               In_Branch,
    output logic               Out_Valid,
    output logic [DATA_W-1:0]  Out_PC,
    output logic [DATA_W-1:0]  Out_RnData,
    output logic [DATA_W-1:0]  Out_RmData,
    output logic [DATA_W-1:0]  Out_Imm,
    output logic [REG_W-1:0]   Out_Rn,
    output logic [REG_W-1:0]   Out_Rm,
    output logic [REG_W-1:0]   Out_Rd,
    output logic               Out_ALUSrc,
    output logic [ALUOP_W-1:0] Out_ALUOp,
    output logic               Out_MemRead,
    output logic               Out_MemWrite,
    output logic               Out_RegWrite,
    output logic               Out_MemToReg,
    output logic               Out_Branch,
    output logic [CNT_W-1:0]   Out_StallCnt,
    output logic [CNT_W-1:0]   Out_BubbleCnt
);

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  rn_data;
        logic [DATA_W-1:0]  rm_data;
        logic [DATA_W-1:0]  imm;
        logic [REG_W-1:0]   rn;
        logic [REG_W-1:0]   rm;
        logic [REG_W-1:0]   rd;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic               branch;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    // Flush beats stall; side-effecting control bits are squashed for invalid slots.
    always_comb begin
        stage_d = stage_q;
        if (Flush) begin
            stage_d = '0;
        end else if (!Stall) begin
            stage_d.valid      = In_Valid;
            stage_d.pc         = In_PC;
            stage_d.rn_data    = In_RnData;
            stage_d.rm_data    = In_RmData;
            stage_d.imm        = In_Imm;
            stage_d.rn         = In_Rn;
            stage_d.rm         = In_Rm;
            stage_d.rd         = In_Rd;
            stage_d.alu_src    = In_ALUSrc;
            stage_d.alu_op     = In_ALUOp;
            stage_d.mem_read   = In_MemRead  & In_Valid;
            stage_d.mem_write  = In_MemWrite & In_Valid;
            stage_d.reg_write  = In_RegWrite & In_Valid;
            stage_d.mem_to_reg = In_MemToReg;
            stage_d.branch     = In_Branch   & In_Valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign Out_Valid    = stage_q.valid;
    assign Out_PC       = stage_q.pc;
    assign Out_RnData   = stage_q.rn_data;
    assign Out_RmData   = stage_q.rm_data;
    assign Out_Imm      = stage_q.imm;
    assign Out_Rn       = stage_q.rn;
    assign Out_Rm       = stage_q.rm;
    assign Out_Rd       = stage_q.rd;
    assign Out_ALUSrc   = stage_q.alu_src;
    assign Out_ALUOp    = stage_q.alu_op;
    assign Out_MemRead  = stage_q.mem_read;
    assign Out_MemWrite = stage_q.mem_write;
    assign Out_RegWrite = stage_q.reg_write;
    assign Out_MemToReg = stage_q.mem_to_reg;
    assign Out_Branch   = stage_q.branch;

`ifdef IDEX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    // Saturating counters; a bubble is any flush or any load of an invalid slot.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (Stall && !Flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((Flush || (!Stall && !In_Valid)) && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign Out_StallCnt  = stall_cnt_q;
    assign Out_BubbleCnt = bubble_cnt_q;
`else
    assign Out_StallCnt  = '0;
    assign Out_BubbleCnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (counter checks adapt to IDEX_PERF_CNT_EN).
module tb_id_ex_pipe_reg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned CNT_W   = 4;
`ifdef IDEX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RESET_N, Stall, Flush, In_Valid;
    logic [DATA_W-1:0]  In_PC, In_RnData, In_RmData, In_Imm;
    logic [REG_W-1:0]   In_Rn, In_Rm, In_Rd;
    logic               In_ALUSrc;
    logic [ALUOP_W-1:0] In_ALUOp;
    logic               In_MemRead, In_MemWrite, In_RegWrite, In_MemToReg, In_Branch;
    logic               Out_Valid;
    logic [DATA_W-1:0]  Out_PC, Out_RnData, Out_RmData, Out_Imm;
    logic [REG_W-1:0]   Out_Rn, Out_Rm, Out_Rd;
    logic               Out_ALUSrc;
    logic [ALUOP_W-1:0] Out_ALUOp;
    logic               Out_MemRead, Out_MemWrite, Out_RegWrite, Out_MemToReg, Out_Branch;
    logic [CNT_W-1:0]   Out_StallCnt, Out_BubbleCnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    id_ex_pipe_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .ALUOP_W(ALUOP_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .Stall        (Stall),
        .Flush        (Flush),
        .In_Valid     (In_Valid),
        .In_PC        (In_PC),
        .In_RnData    (In_RnData),
        .In_RmData    (In_RmData),
        .In_Imm       (In_Imm),
        .In_Rn        (In_Rn),
        .In_Rm        (In_Rm),
        .In_Rd        (In_Rd),
        .In_ALUSrc    (In_ALUSrc),
        .In_ALUOp     (In_ALUOp),
        .In_MemRead   (In_MemRead),
        .In_MemWrite  (In_MemWrite),
        .In_RegWrite  (In_RegWrite),
        .In_MemToReg  (In_MemToReg),
        .In_Branch    (In_Branch),
        .Out_Valid    (Out_Valid),
        .Out_PC       (Out_PC),
        .Out_RnData   (Out_RnData),
        .Out_RmData   (Out_RmData),
        .Out_Imm      (Out_Imm),
        .Out_Rn       (Out_Rn),
        .Out_Rm       (Out_Rm),
        .Out_Rd       (Out_Rd),
        .Out_ALUSrc   (Out_ALUSrc),
        .Out_ALUOp    (Out_ALUOp),
        .Out_MemRead  (Out_MemRead),
        .Out_MemWrite (Out_MemWrite),
        .Out_RegWrite (Out_RegWrite),
        .Out_MemToReg (Out_MemToReg),
        .Out_Branch   (Out_Branch),
        .Out_StallCnt (Out_StallCnt),
        .Out_BubbleCnt(Out_BubbleCnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected counter value: the count itself with counters built, else 0.
    function automatic logic [63:0] ecnt(input int v);
        return PERF ? 64'(v) : 64'd0;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_inputs(input logic v);
        In_Valid = v; In_PC = {DATA_W{v}}; In_RnData = {DATA_W{v}};
        In_RmData = {DATA_W{v}}; In_Imm = {DATA_W{v}};
        In_Rn = {REG_W{v}}; In_Rm = {REG_W{v}}; In_Rd = {REG_W{v}};
        In_ALUSrc = v; In_ALUOp = {ALUOP_W{v}};
        In_MemRead = v; In_MemWrite = v; In_RegWrite = v; In_MemToReg = v; In_Branch = v;
    endtask

    initial begin
        RESET_N = 1'b0; Stall = 1'b0; Flush = 1'b0;
        set_inputs(1'b1);
        step(); step();
        // Reset with all-ones inputs
        check("rst_valid",  64'(Out_Valid), 64'd0);
        check("rst_pc",     Out_PC, 64'd0);
        check("rst_rn",     Out_RnData, 64'd0);
        check("rst_imm",    Out_Imm, 64'd0);
        check("rst_rd",     64'(Out_Rd), 64'd0);
        check("rst_aluop",  64'(Out_ALUOp), 64'd0);
        check("rst_regwr",  64'(Out_RegWrite), 64'd0);
        check("rst_scnt",   64'(Out_StallCnt), 64'd0);
        check("rst_bcnt",   64'(Out_BubbleCnt), 64'd0);

        RESET_N = 1'b1;
        step();
        check("rel_valid",  64'(Out_Valid), 64'd1);
        check("rel_pc",     Out_PC, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rel_rm",     Out_RmData, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rel_rd",     64'(Out_Rd), 64'h1F);
        check("rel_aluop",  64'(Out_ALUOp), 64'hF);
        check("rel_memwr",  64'(Out_MemWrite), 64'd1);
        check("rel_branch", 64'(Out_Branch), 64'd1);

        // Plain load
        set_inputs(1'b0);
        In_Valid = 1'b1; In_RmData = 64'hAA; In_Imm = 64'h10; In_ALUSrc = 1'b1;
        In_RegWrite = 1'b1; In_Rd = 5'd3; In_RnData = 64'h5;
        step();
        check("ld_valid",  64'(Out_Valid), 64'd1);
        check("ld_rm",     Out_RmData, 64'hAA);
        check("ld_imm",    Out_Imm, 64'h10);
        check("ld_alusrc", 64'(Out_ALUSrc), 64'd1);
        check("ld_regwr",  64'(Out_RegWrite), 64'd1);
        check("ld_rd",     64'(Out_Rd), 64'd3);
        check("ld_rn",     Out_RnData, 64'h5);
        check("ld_memwr",  64'(Out_MemWrite), 64'd0);
        check("ld_pc",     Out_PC, 64'd0);

        // Stall three edges while RnData changes
        Stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            In_RnData = 64'(i);
            step();
            check("stl_rn", Out_RnData, 64'h5);
        end
        check("stl_valid", 64'(Out_Valid), 64'd1);
        check("stl_scnt",  64'(Out_StallCnt), ecnt(3));
        Stall = 1'b0;
        step();
        check("unstl_rn",   Out_RnData, 64'h3);
        check("unstl_scnt", 64'(Out_StallCnt), ecnt(3));
        check("unstl_bcnt", 64'(Out_BubbleCnt), ecnt(0));

        // Flush wins over stall
        Stall = 1'b1; Flush = 1'b1;
        step();
        check("fl_valid", 64'(Out_Valid), 64'd0);
        check("fl_regwr", 64'(Out_RegWrite), 64'd0);
        check("fl_rn",    Out_RnData, 64'd0);
        check("fl_imm",   Out_Imm, 64'd0);
        check("fl_rd",    64'(Out_Rd), 64'd0);
        check("fl_bcnt",  64'(Out_BubbleCnt), ecnt(1));
        check("fl_scnt",  64'(Out_StallCnt), ecnt(3));

        // Stall holding a bubble
        Flush = 1'b0;
        step();
        check("stb_valid", 64'(Out_Valid), 64'd0);
        check("stb_rm",    Out_RmData, 64'd0);
        check("stb_scnt",  64'(Out_StallCnt), ecnt(4));

        // Invalid slot: side-effect controls squashed, data still captured
        Stall = 1'b0;
        In_Valid = 1'b0; In_MemWrite = 1'b1; In_RegWrite = 1'b1; In_PC = 64'h40;
        In_MemRead = 1'b1; In_Branch = 1'b1; In_MemToReg = 1'b1;
        step();
        check("inv_valid",  64'(Out_Valid), 64'd0);
        check("inv_memwr",  64'(Out_MemWrite), 64'd0);
        check("inv_regwr",  64'(Out_RegWrite), 64'd0);
        check("inv_memrd",  64'(Out_MemRead), 64'd0);
        check("inv_branch", 64'(Out_Branch), 64'd0);
        check("inv_m2r",    64'(Out_MemToReg), 64'd1);
        check("inv_pc",     Out_PC, 64'h40);
        check("inv_rm",     Out_RmData, 64'hAA);
        check("inv_bcnt",   64'(Out_BubbleCnt), ecnt(2));

        // Reset asserted mid-stall
        In_Valid = 1'b1;
        step();
        check("pre_valid", 64'(Out_Valid), 64'd1);
        Stall = 1'b1; RESET_N = 1'b0;
        step();
        check("rs_valid", 64'(Out_Valid), 64'd0);
        check("rs_pc",    Out_PC, 64'd0);
        check("rs_scnt",  64'(Out_StallCnt), 64'd0);
        check("rs_bcnt",  64'(Out_BubbleCnt), 64'd0);
        RESET_N = 1'b1;
        step();
        check("rs_hold_pc",   Out_PC, 64'd0);
        check("rs_hold_scnt", 64'(Out_StallCnt), ecnt(1));
        Stall = 1'b0;
        step();
        check("rs_ld_valid", 64'(Out_Valid), 64'd1);
        check("rs_ld_pc",    Out_PC, 64'h40);
        check("rs_ld_regwr", 64'(Out_RegWrite), 64'd1);

        // Long stall saturates the 4-bit counter
        Stall = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat_scnt",  64'(Out_StallCnt), ecnt(15));
        check("sat_pc",    Out_PC, 64'h40);
        check("sat_bcnt",  64'(Out_BubbleCnt), ecnt(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the segmented ARMv8 core.
- Captures decoded operands, immediate, destination register and control bits at the end of ID, and presents them to EX one cycle later.
- Its outputs directly feed the EX-stage 64-bit 2:1 operand multiplexers (Out_RmData vs Out_Imm selected by Out_ALUSrc; Out_RnData path).
- Supports stall (hold) and flush (bubble insertion), driven by the hazard unit and branch resolution.

Parameters:
- DATA_W, 64, width of PC, operand and immediate fields.
- REG_W, 5, width of register-index fields.
- ALUOP_W, 4, width of ALU operation code.
- CNT_W, 32, width of optional performance counters.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  synchronous, active-low reset.
- Stall  input  1  hold all stage contents this cycle.
- Flush  input  1  replace next stage contents with a bubble.
- In_Valid  input  1  ID holds a real instruction.
- In_PC  input  DATA_W  PC of ID instruction.
- In_RnData  input  DATA_W  register-file read port 1.
- In_RmData  input  DATA_W  register-file read port 2.
- In_Imm  input  DATA_W  sign-extended immediate.
- In_Rn, In_Rm, In_Rd  input  REG_W each  source/destination indices.
- In_ALUSrc  input  1  1 = immediate operand.
- In_ALUOp  input  ALUOP_W  ALU operation.
- In_MemRead, In_MemWrite, In_RegWrite, In_MemToReg, In_Branch  input  1 each  control bits.
- Out_Valid  output  1  EX holds a real instruction.
- Out_PC, Out_RnData, Out_RmData, Out_Imm  output  DATA_W each  registered copies.
- Out_Rn, Out_Rm, Out_Rd  output  REG_W each  registered copies.
- Out_ALUSrc, Out_ALUOp, Out_MemRead, Out_MemWrite, Out_RegWrite, Out_MemToReg, Out_Branch  output  matching widths  registered control.
- Out_StallCnt  output  CNT_W  stall-cycle count.
- Out_BubbleCnt  output  CNT_W  bubble count.

Behaviour:
- All state updates on rising CLK; latency exactly 1 cycle from In_* to Out_*.
- Every output is a flop; no combinational path input→output.
- Priority per edge: RESET_N=0 > Flush=1 > Stall=1 > normal load.
- Reset: every output, including counters, = 0.
- Flush: Out_Valid=0; all control bits and Out_ALUOp=0; data and index fields = 0. This holds regardless of Stall.
- Stall (no Flush): every output holds its previous value, Out_Valid included.
- Normal load: all fields capture In_*; Out_Valid=In_Valid.
- If In_Valid=0, Out_MemRead, Out_MemWrite, Out_RegWrite and Out_Branch are forced 0. Data fields are still captured.
- Invariant: Out_Valid=0 implies Out_MemWrite=Out_RegWrite=Out_MemRead=Out_Branch=0.
- Reset asserted mid-stall or mid-flush clears on that edge; the first non-reset edge after deassertion follows the normal priority.
- Stall held for N cycles leaves outputs unchanged for N edges; the first edge with Stall=0 loads the current In_*.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - Out_StallCnt increments on each non-reset edge with Stall=1 and Flush=0.
  - Out_BubbleCnt increments on each non-reset edge where Out_Valid becomes 0 via Flush or In_Valid=0 load.
  - Both counters saturate at all-ones (no wrap) and clear only on reset.
- Not defined: counter flops are not built; both ports are tied to constant 0.

Test Plan:
- Reset: drive RESET_N=0 with all In_*=all-ones for 2 edges -> all outputs 0; release -> next edge outputs equal In_*.
- Load: In_Valid=1, In_RmData=64'h0000_0000_0000_00AA, In_Imm=64'h0000_0000_0000_0010, In_ALUSrc=1, In_RegWrite=1, In_Rd=5'd3 -> after 1 edge outputs match exactly, Out_Valid=1.
- Stall: Stall=1 for 3 edges while In_RnData changes 1→2→3 -> Out_RnData keeps the pre-stall value. Release -> Out_RnData=3. With IDEX_PERF_CNT_EN, Out_StallCnt=3.
- Flush priority: Stall=1 and Flush=1 on the same edge with Out_RegWrite=1 held -> Out_Valid=0, Out_RegWrite=0, Out_RnData=0. With macro, Out_BubbleCnt increments by 1.
- Invalid input: In_Valid=0, In_MemWrite=1, In_RegWrite=1, In_PC=64'h40 -> Out_MemWrite=0, Out_RegWrite=0, Out_PC=64'h40, Out_Valid=0.
- Saturation (macro defined, CNT_W overridden to 4): hold Stall=1 for 20 edges -> Out_StallCnt=4'hF, no wrap.
